// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared types and default parameter values for the counter sequence checker.
//   chk_state_t : checker FSM state (UNSYNC, ACQUIRE, LOCKED), 2-bit encoding
//   DEF_*       : default values for the checker parameters
// -----------------------------------------------------------------------------
package counter_pkg;

  typedef enum logic [1:0] {
    UNSYNC  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } chk_state_t;

  localparam int DEF_WIDTH    = 2;
  localparam int DEF_LOCK_CNT = 2;
  localparam int DEF_STAT_W   = 8;

endpackage : counter_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating event counter used for the checker statistics.
// Ports:
//   clk    in  1       : rising-edge clock
//   reset  in  1       : synchronous active-high reset, highest priority
//   clear  in  1       : synchronous clear, wins over a same-cycle increment
//   inc    in  1       : count one event
//   value  out STAT_W  : registered count, holds at all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int STAT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  output logic [STAT_W-1:0] value
);

  // Count register: reset > clear > saturating increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= {STAT_W{1'b0}};
    end else if (clear) begin
      value <= {STAT_W{1'b0}};
    end else if (inc && (value != {STAT_W{1'b1}})) begin
      value <= value + STAT_W'(1'b1);
    end
  end

endmodule : sat_counter

// File: rtl/counter_seq_checker.sv
// -----------------------------------------------------------------------------
// counter_seq_checker
// Checks that a free-running up-counter advances by exactly one (mod 2^WIDTH)
// on every qualified sample. Locks after LOCK_CNT consecutive good increments,
// reports breaks and wraps while locked, and re-acquires on its own.
// Ports:
//   clk         in  1      : rising-edge clock
//   reset       in  1      : synchronous active-high reset
//   sample_en   in  1      : qualifies count_in
//   count_in    in  WIDTH  : counter value under test
//   clear       in  1      : clears err_count and wrap_count
//   locked      out 1      : high while locked
//   seq_err     out 1      : one-cycle pulse per sequence break while locked
//   wrap        out 1      : one-cycle pulse per correct max->0 step while locked
//   err_count   out STAT_W : saturating count of seq_err pulses
//   wrap_count  out STAT_W : saturating count of wrap pulses
// -----------------------------------------------------------------------------
module counter_seq_checker
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int STAT_W   = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              clear,
  output logic              locked,
  output logic              seq_err,
  output logic              wrap,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count
);

  chk_state_t       state_r;
  logic [WIDTH-1:0] prev_r;
  logic [7:0]       good_run_r;

  logic [WIDTH-1:0] exp_s;
  logic             match_s;
  logic [7:0]       good_run_next_s;
  logic             err_hit_s;
  logic             wrap_hit_s;

  // Expected next value and the event decisions for the current sample.
  always_comb begin
    exp_s           = prev_r + WIDTH'(1'b1);
    match_s         = (count_in == exp_s);
    good_run_next_s = good_run_r + 8'd1;
    err_hit_s       = 1'b0;
    wrap_hit_s      = 1'b0;
    if (sample_en && (state_r == LOCKED)) begin
      err_hit_s  = !match_s;
      // A correct step out of all-ones is the wrap to zero.
      wrap_hit_s = match_s && (&prev_r);
    end else begin
      err_hit_s  = 1'b0;
      wrap_hit_s = 1'b0;
    end
  end

  // Checker FSM with prev/good_run tracking and registered flag outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= UNSYNC;
      prev_r     <= {WIDTH{1'b0}};
      good_run_r <= 8'd0;
      locked     <= 1'b0;
      seq_err    <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      seq_err <= err_hit_s;
      wrap    <= wrap_hit_s;
      if (sample_en) begin
        prev_r <= count_in;
        case (state_r)
          UNSYNC: begin
            good_run_r <= 8'd0;
            state_r    <= ACQUIRE;
            locked     <= 1'b0;
          end
          ACQUIRE: begin
            if (match_s) begin
              good_run_r <= good_run_next_s;
              if (good_run_next_s == 8'(LOCK_CNT)) begin
                state_r <= LOCKED;
                locked  <= 1'b1;
              end
            end else begin
              good_run_r <= 8'd0;
            end
          end
          LOCKED: begin
            if (!match_s) begin
              good_run_r <= 8'd0;
              state_r    <= ACQUIRE;
              locked     <= 1'b0;
            end
          end
          default: begin
            good_run_r <= 8'd0;
            state_r    <= UNSYNC;
            locked     <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.STAT_W(STAT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (err_hit_s),
    .value (err_count)
  );

  sat_counter #(.STAT_W(STAT_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (wrap_hit_s),
    .value (wrap_count)
  );

endmodule : counter_seq_checker

// File: tb/tb_counter_seq_checker.sv
module tb_counter_seq_checker;

  localparam int WIDTH    = 2;
  localparam int LOCK_CNT = 2;
  localparam int STAT_W   = 2;
  localparam int MODV     = 1 << WIDTH;
  localparam int SATV     = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              sample_en;
  logic [WIDTH-1:0]  count_in;
  logic              clear;
  logic              locked;
  logic              seq_err;
  logic              wrap;
  logic [STAT_W-1:0] err_count;
  logic [STAT_W-1:0] wrap_count;

  counter_seq_checker #(
    .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .count_in(count_in),
    .clear(clear), .locked(locked), .seq_err(seq_err), .wrap(wrap),
    .err_count(err_count), .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: length of the trailing run of correct increments.
  int m_nsamp;
  int m_last;
  int m_run;
  int m_locked, m_seq, m_wrap, m_ecnt, m_wcnt;

  typedef struct {
    logic rst; logic se; int cnt; logic clr;
    int locked; int seq; int wrp; int ec; int wc;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, act, expv);
    end
  endtask

  task automatic model_update(input logic r, input logic se, input int ci, input logic clr);
    int was_locked, inc;
    if (r) begin
      m_nsamp = 0; m_run = 0; m_last = 0;
      m_locked = 0; m_seq = 0; m_wrap = 0; m_ecnt = 0; m_wcnt = 0;
    end else begin
      m_seq = 0; m_wrap = 0;
      if (se) begin
        if (m_nsamp == 0) begin
          m_run = 0;
          m_nsamp = 1;
        end else begin
          was_locked = (m_run >= LOCK_CNT);
          inc = (ci == ((m_last + 1) % MODV));
          if (was_locked && !inc) m_seq = 1;
          if (was_locked && inc && m_last == MODV - 1) m_wrap = 1;
          m_run = inc ? m_run + 1 : 0;
        end
        m_last = ci;
        m_locked = (m_run >= LOCK_CNT);
      end
      if (clr) begin
        m_ecnt = 0; m_wcnt = 0;
      end else begin
        if (m_seq && m_ecnt < SATV) m_ecnt++;
        if (m_wrap && m_wcnt < SATV) m_wcnt++;
      end
    end
  endtask

  task automatic step(input logic r, input logic se, input int ci, input logic clr);
    reset = r; sample_en = se; count_in = WIDTH'(ci); clear = clr;
    @(posedge clk);
    #1;
    model_update(r, se, ci, clr);
    chk("model_locked", int'(locked), m_locked);
    chk("model_seq_err", int'(seq_err), m_seq);
    chk("model_wrap", int'(wrap), m_wrap);
    chk("model_err_count", int'(err_count), m_ecnt);
    chk("model_wrap_count", int'(wrap_count), m_wcnt);
  endtask

  task automatic addv(input logic r, input logic se, input int c, input logic cl,
                      input int l, input int s, input int w, input int e, input int wc);
    vec_t v;
    v.rst = r; v.se = se; v.cnt = c; v.clr = cl;
    v.locked = l; v.seq = s; v.wrp = w; v.ec = e; v.wc = wc;
    tbl.push_back(v);
  endtask

  initial begin
    int cur;
    reset = 1'b1; sample_en = 1'b0; count_in = '0; clear = 1'b0;
    model_update(1'b1, 1'b0, 0, 1'b0);

    // rst se cnt clr | locked seq wrap ec wc
    addv(1'b1, 1'b0, 0, 1'b0, 0, 0, 0, 0, 0);
    addv(1'b0, 1'b1, 0, 1'b0, 0, 0, 0, 0, 0);
    addv(1'b0, 1'b1, 1, 1'b0, 0, 0, 0, 0, 0);
    addv(1'b0, 1'b1, 2, 1'b0, 1, 0, 0, 0, 0);
    addv(1'b0, 1'b1, 3, 1'b0, 1, 0, 0, 0, 0);
    addv(1'b0, 1'b1, 0, 1'b0, 1, 0, 1, 0, 1);
    addv(1'b0, 1'b1, 1, 1'b0, 1, 0, 0, 0, 1);
    addv(1'b0, 1'b1, 2, 1'b0, 1, 0, 0, 0, 1);
    addv(1'b0, 1'b1, 3, 1'b0, 1, 0, 0, 0, 1);
    addv(1'b0, 1'b1, 0, 1'b0, 1, 0, 1, 0, 2);
    // skip 1,2,0
    addv(1'b0, 1'b1, 1, 1'b0, 1, 0, 0, 0, 2);
    addv(1'b0, 1'b1, 2, 1'b0, 1, 0, 0, 0, 2);
    addv(1'b0, 1'b1, 0, 1'b0, 0, 1, 0, 1, 2);
    addv(1'b0, 1'b1, 1, 1'b0, 0, 0, 0, 1, 2);
    addv(1'b0, 1'b1, 2, 1'b0, 1, 0, 0, 1, 2);
    // held value 3,3
    addv(1'b0, 1'b1, 3, 1'b0, 1, 0, 0, 1, 2);
    addv(1'b0, 1'b1, 3, 1'b0, 0, 1, 0, 2, 2);
    addv(1'b0, 1'b1, 0, 1'b0, 0, 0, 0, 2, 2);
    addv(1'b0, 1'b1, 1, 1'b0, 1, 0, 0, 2, 2);
    // sample_en 1,0,0,1 with junk on the gaps
    addv(1'b0, 1'b1, 2, 1'b0, 1, 0, 0, 2, 2);
    addv(1'b0, 1'b0, 0, 1'b0, 1, 0, 0, 2, 2);
    addv(1'b0, 1'b0, 1, 1'b0, 1, 0, 0, 2, 2);
    addv(1'b0, 1'b1, 3, 1'b0, 1, 0, 0, 2, 2);
    addv(1'b0, 1'b1, 0, 1'b0, 1, 0, 1, 2, 3);
    // clear alone
    addv(1'b0, 1'b0, 0, 1'b1, 1, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].se, tbl[i].cnt, tbl[i].clr);
      chk("tbl_locked", int'(locked), tbl[i].locked);
      chk("tbl_seq_err", int'(seq_err), tbl[i].seq);
      chk("tbl_wrap", int'(wrap), tbl[i].wrp);
      chk("tbl_err_count", int'(err_count), tbl[i].ec);
      chk("tbl_wrap_count", int'(wrap_count), tbl[i].wc);
    end

    // Saturation: five errors into a 2-bit counter, then clear with a sixth.
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 0, 1'b0);
    step(1'b0, 1'b1, 1, 1'b0);
    step(1'b0, 1'b1, 2, 1'b0);
    chk("sat_prelock", int'(locked), 1);
    cur = 2;
    for (int k = 0; k < 5; k++) begin
      cur = (cur + 2) % MODV;
      step(1'b0, 1'b1, cur, 1'b0);
      chk("sat_seq_err", int'(seq_err), 1);
      cur = (cur + 1) % MODV;
      step(1'b0, 1'b1, cur, 1'b0);
      cur = (cur + 1) % MODV;
      step(1'b0, 1'b1, cur, 1'b0);
      chk("sat_relock", int'(locked), 1);
    end
    chk("sat_err_count", int'(err_count), 3);
    cur = (cur + 2) % MODV;
    step(1'b0, 1'b1, cur, 1'b1);
    chk("clr_seq_err", int'(seq_err), 1);
    chk("clr_err_count", int'(err_count), 0);

    // Reset mid-lock, then re-acquire.
    cur = (cur + 1) % MODV;
    step(1'b0, 1'b1, cur, 1'b0);
    cur = (cur + 1) % MODV;
    step(1'b0, 1'b1, cur, 1'b0);
    chk("prereset_locked", int'(locked), 1);
    step(1'b1, 1'b1, 1, 1'b0);
    chk("rst_outputs", int'({locked, seq_err, wrap, err_count, wrap_count}), 0);
    step(1'b0, 1'b1, 1, 1'b0);
    chk("relock_e1", int'(locked), 0);
    step(1'b0, 1'b1, 2, 1'b0);
    chk("relock_e2", int'(locked), 0);
    step(1'b0, 1'b1, 3, 1'b0);
    chk("relock_e3", int'(locked), 1);

    // Randomized stream: mostly correct counts with gaps, faults, clears, resets.
    cur = 3;
    for (int n = 0; n < 600; n++) begin
      logic r, se, cl;
      int v;
      r  = ($urandom_range(0, 79) == 0);
      se = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 39) == 0);
      if (se) begin
        if ($urandom_range(0, 9) == 0) v = $urandom_range(0, MODV - 1);
        else v = (cur + 1) % MODV;
        cur = v;
      end else begin
        v = $urandom_range(0, MODV - 1);
      end
      step(r, se, v, cl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_counter_seq_checker
